pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer.sv | 142 ++++++++++++++
 tb/tb_pixel_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// Pixel writer: clips incoming pixels to the framebuffer, queues on-screen
// pixels as {address, colour} in a small FIFO and issues them as single writes.
module pixel_writer #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 19,
    parameter int COLOR_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [15:0]        pix_x,
    input  logic [15:0]        pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic               mem_ack,
    output logic               busy,
    output logic [15:0]        clip_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + COLOR_W;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    // state | meaning
    // IDLE  | no write outstanding; pops the FIFO head when one is present
    // REQ   | mem_req held with stable address/data until mem_ack
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t               state_q;
    logic                 mem_req_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [COLOR_W-1:0]   mem_wdata_q;

    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [15:0]          clip_q, clip_d;
    logic [ENT_W-1:0]     fifo_mem_q [DEPTH];

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;
    logic                 on_screen;
    logic                 push;
    logic                 pop;
    logic [ADDR_W-1:0]    lin_addr;
    logic [ENT_W-1:0]     head;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign pix_ready = !fifo_full;
    assign accept    = pix_valid && pix_ready;
    assign on_screen = ({16'b0, pix_x} < 32'(FB_WIDTH)) &&
                       ({16'b0, pix_y} < 32'(FB_HEIGHT));
    assign push      = accept && on_screen;
    assign pop       = (state_q == ST_IDLE) && !fifo_empty;

    // Computed in ADDR_W-bit arithmetic, so the result is already truncated.
    assign lin_addr  = ADDR_W'(pix_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(pix_x);
    assign head      = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        clip_d   = clip_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (accept && !on_screen && (clip_q != 16'hFFFF)) begin
            clip_d = clip_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            clip_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            clip_q   <= clip_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {lin_addr, pix_color};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        mem_addr_q  <= head[ENT_W-1:COLOR_W];
                        mem_wdata_q <= head[COLOR_W-1:0];
                        mem_req_q   <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = !fifo_empty || (state_q == ST_REQ);
    assign clip_count = clip_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_pixel_writer;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int D  = 8;
    localparam int AW = 19;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          pix_valid;
    logic          pix_ready;
    logic [15:0]   pix_x;
    logic [15:0]   pix_y;
    logic [CW-1:0] pix_color;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;
    logic          mem_ack;
    logic          busy;
    logic [15:0]   clip_count;

    pixel_writer #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .DEPTH(D), .ADDR_W(AW), .COLOR_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .busy(busy), .clip_count(clip_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int addr;
        int color;
    } wr_t;

    typedef struct {
        int   x;
        int   y;
        int   color;
        bit   on;
        int   addr;
    } vec_t;

    // Reference model: pending writes in acceptance order plus the one in flight.
    wr_t mq[$];
    bit  m_req;
    int  m_addr;
    int  m_data;
    int  m_clip;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_req  = 1'b0;
        m_addr = 0;
        m_data = 0;
        m_clip = 0;
    endtask

    // Called at a negedge: drives inputs, advances the model over the next
    // rising edge, then compares the DUT at the following negedge.
    task automatic step(input bit v, input int x, input int y, input int c,
                        input bit ack, output bit acc);
        wr_t e;
        pix_valid = v;
        pix_x     = x[15:0];
        pix_y     = y[15:0];
        pix_color = c[CW-1:0];
        mem_ack   = ack;
        acc = v && (mq.size() < D);
        if (m_req) begin
            if (ack) m_req = 1'b0;
        end else if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_req  = 1'b1;
            m_addr = e.addr;
            m_data = e.color;
        end
        if (acc) begin
            if (x >= W || y >= H) begin
                if (m_clip < 65535) m_clip++;
            end else begin
                e.addr  = (y * W + x) % (1 << AW);
                e.color = c % (1 << CW);
                mq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("pix_ready", {31'b0, pix_ready}, {31'b0, (mq.size() < D)});
        chk("mem_req", {31'b0, mem_req}, {31'b0, m_req});
        if (m_req) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_data));
        end
        chk("busy", {31'b0, busy}, {31'b0, (mq.size() > 0) || m_req});
        chk("clip_count", {16'b0, clip_count}, 32'(m_clip));
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        pix_color = '0;
        mem_ack   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_clip"}, {16'b0, clip_count}, 32'd0);
        chk({tag, "_ready"}, {31'b0, pix_ready}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        bit  acc;
        int  n_acc;
        int  k;
        int  drops;
        int  req_seen;
        wr_t got[$];
        wr_t g;

        tbl[0] = '{x: 10,    y: 2,     color: 'h5A, on: 1'b1, addr: 1290};
        tbl[1] = '{x: 639,   y: 479,   color: 'hFF, on: 1'b1, addr: 307199};
        tbl[2] = '{x: 640,   y: 0,     color: 'h11, on: 1'b0, addr: 0};
        tbl[3] = '{x: 0,     y: 480,   color: 'h22, on: 1'b0, addr: 0};
        tbl[4] = '{x: 0,     y: 0,     color: 'h33, on: 1'b1, addr: 0};
        tbl[5] = '{x: 65535, y: 65535, color: 'h44, on: 1'b0, addr: 0};
        tbl[6] = '{x: 639,   y: 0,     color: 'h55, on: 1'b1, addr: 639};
        tbl[7] = '{x: 0,     y: 1,     color: 'h66, on: 1'b1, addr: 640};

        // Reset values visible before any clock edge.
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: each pixel alone, mem_ack tied high.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].x, tbl[i].y, tbl[i].color, 1'b1, acc);
            chk("tbl_accept", {31'b0, acc}, 32'd1);
            step(1'b0, 0, 0, 0, 1'b1, acc);
            chk("tbl_req", {31'b0, mem_req}, {31'b0, tbl[i].on});
            if (tbl[i].on) begin
                chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].addr));
                chk("tbl_data", 32'(mem_wdata), 32'(tbl[i].color));
            end
            step(1'b0, 0, 0, 0, 1'b1, acc);
            chk("tbl_req_drop", {31'b0, mem_req}, 32'd0);
            chk("tbl_busy_idle", {31'b0, busy}, 32'd0);
        end
        chk("tbl_clip_total", {16'b0, clip_count}, 32'd3);

        // Backpressure: 10 offered with mem_ack low, 9 accepted, drained in order.
        n_acc = 0;
        k = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, k, 3, 'h80 + k, 1'b0, acc);
            if (acc) begin
                n_acc++;
                k++;
            end
            if (k == 10) break;
        end
        chk("bp_accepts", 32'(n_acc), 32'd9);
        chk("bp_ready_low", {31'b0, pix_ready}, 32'd0);
        got.delete();
        for (int i = 0; i < 40; i++) begin
            if (mem_req) begin
                g.addr  = int'(mem_addr);
                g.color = int'(mem_wdata);
                got.push_back(g);
            end
            if (got.size() >= 9 && !busy) break;
            step(1'b0, 0, 0, 0, 1'b1, acc);
        end
        chk("bp_drained", 32'(got.size()), 32'd9);
        for (int i = 0; i < got.size() && i < 9; i++) begin
            chk("bp_order_addr", 32'(got[i].addr), 32'(3 * W + i));
            chk("bp_order_data", 32'(got[i].color), 32'('h80 + i));
        end

        // Streaming at the sustainable rate, including same-edge push and pop.
        drops = 0;
        for (int i = 0; i < 40; i++) begin
            step((i % 4) < 2, i, 7, i, 1'b1, acc);
            if (!pix_ready) drops++;
        end
        chk("stream_ready_drops", 32'(drops), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 0, 1'b1, acc);

        // Reset while a write is outstanding and three entries are queued.
        for (int i = 0; i < 4; i++) step(1'b1, 20 + i, 9, 'hC0 + i, 1'b0, acc);
        chk("mid_pre_req", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_reset_outputs("mid");
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5, 5, 'h77, 1'b1, acc);
        chk("post_rst_accept", {31'b0, acc}, 32'd1);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 0, 0, 0, 1'b1, acc);
            if (mem_req) begin
                req_seen++;
                chk("post_rst_addr", 32'(mem_addr), 32'd3205);
            end
        end
        chk("post_rst_writes", 32'(req_seen), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 700), $urandom_range(0, 520),
                 $urandom_range(0, 255), $urandom_range(0, 1) == 1, acc);
        end

        // Saturation of the clip counter.
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, 640, 0, 0, 1'b1, acc);
            if (i == 65534) chk("sat_reach", {16'b0, clip_count}, 32'hFFFF);
        end
        chk("sat_hold", {16'b0, clip_count}, 32'hFFFF);
        chk("sat_no_req", {31'b0, mem_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
